// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode/Execute boundary signals between the core pipeline and the hazard controller.
// The master side is the pipeline; the slave side is the controller.
interface pipeline_hazard_ctrl_if;
    logic       id_valid;
    logic [3:0] id_opcode;
    logic [4:0] id_src1;
    logic [4:0] id_src2;
    logic [4:0] id_dest;
    logic       ex_zf;
    logic       ex_gf;
    logic       ex_lf;
    logic       stall;
    logic       flush_if_id;
    logic       bubble_id_ex;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic       branch_taken;
    logic [2:0] flags_q;
    logic [1:0] ctrl_state;

    modport master (
        output id_valid, id_opcode, id_src1, id_src2, id_dest, ex_zf, ex_gf, ex_lf,
        input  stall, flush_if_id, bubble_id_ex, fwd_sel1, fwd_sel2, branch_taken,
               flags_q, ctrl_state
    );

    modport slave (
        input  id_valid, id_opcode, id_src1, id_src2, id_dest, ex_zf, ex_gf, ex_lf,
        output stall, flush_if_id, bubble_id_ex, fwd_sel1, fwd_sel2, branch_taken,
               flags_q, ctrl_state
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 16-bit core: shadows EX/MEM/WB destinations, drives operand
// forwarding, load-use stalls, flag-based jump resolution and wrong-path squashing.
module pipeline_hazard_ctrl #(
    parameter int unsigned INIT_FLUSH_CYCLES = 2,
    parameter bit          ZERO_REG_EN       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam int unsigned OP_W   = 4;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 3;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned FLAG_W = 3;

    localparam logic [OP_W-1:0] OP_NOP    = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB    = 4'd1;
    localparam logic [OP_W-1:0] OP_ADD    = 4'd2;
    localparam logic [OP_W-1:0] OP_ADDI   = 4'd3;
    localparam logic [OP_W-1:0] OP_SHLLI  = 4'd4;
    localparam logic [OP_W-1:0] OP_SHRLI  = 4'd5;
    localparam logic [OP_W-1:0] OP_JUMP   = 4'd6;
    localparam logic [OP_W-1:0] OP_JUMPL  = 4'd7;
    localparam logic [OP_W-1:0] OP_JUMPG  = 4'd8;
    localparam logic [OP_W-1:0] OP_JUMPE  = 4'd9;
    localparam logic [OP_W-1:0] OP_JUMPNE = 4'd10;
    localparam logic [OP_W-1:0] OP_CMP    = 4'd11;
    localparam logic [OP_W-1:0] OP_LOAD   = 4'd12;
    localparam logic [OP_W-1:0] OP_LOADI  = 4'd13;
    localparam logic [OP_W-1:0] OP_STORE  = 4'd14;
    localparam logic [OP_W-1:0] OP_MOV    = 4'd15;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LU_STALL = 2'd2
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  dest;
    } slot_t;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    slot_t               ex_q, mem_q, wb_q, ex_d;
    logic [FLAG_W-1:0]   flags_q;

    logic                live1, live2, load_use, br_taken;
    logic                stall, flush_if_id, bubble_id_ex;
    logic [SEL_W-1:0]    fwd1_raw, fwd2_raw, fwd_sel1, fwd_sel2;

    function automatic logic writes_f(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI,
            OP_LOAD, OP_LOADI, OP_MOV: writes_f = 1'b1;
            default:                   writes_f = 1'b0;
        endcase
    endfunction

    function automatic logic uses1_f(input logic [OP_W-1:0] op);
        case (op)
            OP_NOP, OP_LOADI: uses1_f = 1'b0;
            default:          uses1_f = 1'b1;
        endcase
    endfunction

    function automatic logic uses2_f(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB, OP_ADD, OP_CMP, OP_STORE: uses2_f = 1'b1;
            default:                          uses2_f = 1'b0;
        endcase
    endfunction

    function automatic logic hit_f(input slot_t s, input logic [REG_W-1:0] idx);
        hit_f = s.valid && writes_f(s.op) && (s.dest == idx);
    endfunction

    // Youngest producer wins; a LOAD in EX has no result yet, so it is skipped here.
    function automatic logic [SEL_W-1:0] fwd_f(input logic live, input logic [REG_W-1:0] idx,
                                               input slot_t ex, input slot_t mem, input slot_t wb);
        if (!live)                                 fwd_f = SEL_W'(0);
        else if (hit_f(ex, idx) && ex.op != OP_LOAD) fwd_f = SEL_W'(1);
        else if (hit_f(mem, idx))                  fwd_f = SEL_W'(2);
        else if (hit_f(wb, idx))                   fwd_f = SEL_W'(3);
        else                                       fwd_f = SEL_W'(0);
    endfunction

    // Source qualification, hazard and branch decode from registered state plus ID inputs
    always_comb begin
        live1 = bus.id_valid && uses1_f(bus.id_opcode) &&
                !(ZERO_REG_EN && (bus.id_src1 == REG_W'(0)));
        live2 = bus.id_valid && uses2_f(bus.id_opcode) &&
                !(ZERO_REG_EN && (bus.id_src2 == REG_W'(0)));
        load_use = ex_q.valid && (ex_q.op == OP_LOAD) &&
                   ((live1 && (ex_q.dest == bus.id_src1)) ||
                    (live2 && (ex_q.dest == bus.id_src2)));
        fwd1_raw = fwd_f(live1, bus.id_src1, ex_q, mem_q, wb_q);
        fwd2_raw = fwd_f(live2, bus.id_src2, ex_q, mem_q, wb_q);
        br_taken = 1'b0;
        if (ex_q.valid) begin
            case (ex_q.op)
                OP_JUMP:   br_taken = 1'b1;
                OP_JUMPL:  br_taken = flags_q[0];
                OP_JUMPG:  br_taken = flags_q[1];
                OP_JUMPE:  br_taken = flags_q[2];
                OP_JUMPNE: br_taken = !flags_q[2];
                default:   br_taken = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= CNT_W'(INIT_FLUSH_CYCLES);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INIT: begin
                if (cnt_q <= CNT_W'(1)) state_d = ST_RUN;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RUN: begin
                if (!br_taken && load_use) state_d = ST_LU_STALL;
            end
            ST_LU_STALL: state_d = ST_RUN;
            default:     state_d = ST_INIT;
        endcase
    end

    // Branch redirect outranks a load-use stall; LU_STALL never re-stalls off its own bubble
    always_comb begin
        stall        = 1'b0;
        flush_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        fwd_sel1     = SEL_W'(0);
        fwd_sel2     = SEL_W'(0);
        if (state_q == ST_INIT) begin
            stall        = 1'b1;
            flush_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
        end else begin
            fwd_sel1 = fwd1_raw;
            fwd_sel2 = fwd2_raw;
            if (br_taken) begin
                flush_if_id  = 1'b1;
                bubble_id_ex = 1'b1;
            end else if ((state_q == ST_RUN) && load_use) begin
                stall        = 1'b1;
                bubble_id_ex = 1'b1;
            end
        end
    end

    always_comb begin
        ex_d = '0;
        if (!bubble_id_ex && bus.id_valid) begin
            ex_d.valid = 1'b1;
            ex_d.op    = bus.id_opcode;
            ex_d.dest  = bus.id_dest;
        end
    end

    // Shadow slots advance every cycle; flags are captured while a CMP sits in EX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            flags_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
            if (ex_q.valid && (ex_q.op == OP_CMP))
                flags_q <= {bus.ex_zf, bus.ex_gf, bus.ex_lf};
        end
    end

    assign bus.stall        = stall;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.bubble_id_ex = bubble_id_ex;
    assign bus.fwd_sel1     = fwd_sel1;
    assign bus.fwd_sel2     = fwd_sel2;
    assign bus.branch_taken = br_taken && (state_q != ST_INIT);
    assign bus.flags_q      = flags_q;
    assign bus.ctrl_state   = 2'(state_q);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset/INIT flush, forwarding distances,
// load-use stall, flag-driven jumps, zero register and mid-stall reset.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .INIT_FLUSH_CYCLES(2),
        .ZERO_REG_EN      (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    localparam logic [3:0] NOP = 4'd0, SUB = 4'd1, ADD = 4'd2, JUMP = 4'd6, JUMPL = 4'd7,
                           JUMPG = 4'd8, JUMPE = 4'd9, JUMPNE = 4'd10, CMP = 4'd11,
                           LOAD = 4'd12, LOADI = 4'd13, STORE = 4'd14, MOV = 4'd15;

    int asserts  = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [4:0] d);
        bus.id_valid  = v;
        bus.id_opcode = op;
        bus.id_src1   = s1;
        bus.id_src2   = s2;
        bus.id_dest   = d;
        #1;
    endtask

    task automatic set_flags(input logic z, input logic g, input logic l);
        bus.ex_zf = z;
        bus.ex_gf = g;
        bus.ex_lf = l;
    endtask

    task automatic drain();
        drive(1'b1, NOP, 5'd0, 5'd0, 5'd0);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        logic [3:0] ctl;
        reset = 1'b1;
        set_flags(1'b0, 1'b0, 1'b0);
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
            asserts++;
            if (ctl !== 4'b1110 || bus.ctrl_state !== 2'd0 || bus.flags_q !== 3'b000 ||
                {bus.fwd_sel1, bus.fwd_sel2} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold[%0d]: ctl=%b st=%0d flags=%b fwd=%0d/%0d expected ctl=1110 st=0 flags=000 fwd=0/0",
                         i, ctl, bus.ctrl_state, bus.flags_q, bus.fwd_sel1, bus.fwd_sel2);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
            asserts++;
            if (ctl !== 4'b1110 || bus.ctrl_state !== 2'd0 || bus.fwd_sel1 !== 2'd0) begin
                failures++;
                $display("FAIL init_flush[%0d]: ctl=%b st=%0d fwd1=%0d expected ctl=1110 st=0 fwd1=0",
                         i, ctl, bus.ctrl_state, bus.fwd_sel1);
            end
            tick();
        end
        ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
        asserts++;
        if (ctl !== 4'b0000 || bus.ctrl_state !== 2'd1 || {bus.fwd_sel1, bus.fwd_sel2} !== 4'b0000) begin
            failures++;
            $display("FAIL init_to_run: ctl=%b st=%0d fwd=%0d/%0d expected ctl=0000 st=1 fwd=0/0",
                     ctl, bus.ctrl_state, bus.fwd_sel1, bus.fwd_sel2);
        end
    endtask

    task automatic test_forwarding();
        logic [1:0] exp_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int n = 0; n < 4; n++) begin
            drive(1'b1, ADD, 5'd1, 5'd3, 5'd2);
            tick();
            for (int k = 0; k < n; k++) begin
                drive(1'b1, NOP, 5'd0, 5'd0, 5'd0);
                tick();
            end
            drive(1'b1, SUB, 5'd2, 5'd5, 5'd4);
            asserts++;
            if (bus.fwd_sel1 !== exp_sel[n] || bus.fwd_sel2 !== 2'd0 || bus.stall !== 1'b0) begin
                failures++;
                $display("FAIL fwd_distance_%0d: sel1=%0d sel2=%0d stall=%b expected sel1=%0d sel2=0 stall=0",
                         n, bus.fwd_sel1, bus.fwd_sel2, bus.stall, exp_sel[n]);
            end
            tick();
            drain();
        end
        // Two producers of R2 in flight: the younger (EX) one must win
        drive(1'b1, ADD, 5'd1, 5'd3, 5'd2);
        tick();
        drive(1'b1, MOV, 5'd7, 5'd0, 5'd2);
        tick();
        drive(1'b1, STORE, 5'd9, 5'd2, 5'd0);
        asserts++;
        if (bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd1) begin
            failures++;
            $display("FAIL fwd_priority: sel1=%0d sel2=%0d expected sel1=0 sel2=1", bus.fwd_sel1, bus.fwd_sel2);
        end
        tick();
        drain();
        drive(1'b1, ADD, 5'd1, 5'd3, 5'd6);
        tick();
        drive(1'b1, SUB, 5'd6, 5'd6, 5'd1);
        asserts++;
        if ({bus.fwd_sel1, bus.fwd_sel2} !== 4'b0101) begin
            failures++;
            $display("FAIL fwd_both: sel=%0d/%0d expected 1/1", bus.fwd_sel1, bus.fwd_sel2);
        end
        drive(1'b0, SUB, 5'd6, 5'd6, 5'd1);
        asserts++;
        if ({bus.fwd_sel1, bus.fwd_sel2} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_id_invalid: sel=%0d/%0d expected 0/0", bus.fwd_sel1, bus.fwd_sel2);
        end
        drive(1'b1, LOADI, 5'd6, 5'd6, 5'd1);
        asserts++;
        if ({bus.fwd_sel1, bus.fwd_sel2} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_unused_src: sel=%0d/%0d expected 0/0", bus.fwd_sel1, bus.fwd_sel2);
        end
        tick();
        drain();
    endtask

    task automatic test_load_use();
        logic [3:0] ctl;
        drive(1'b1, LOAD, 5'd6, 5'd0, 5'd2);
        tick();
        drive(1'b1, ADD, 5'd2, 5'd1, 5'd3);
        ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
        asserts++;
        if (ctl !== 4'b1010 || bus.ctrl_state !== 2'd1) begin
            failures++;
            $display("FAIL lu_stall: ctl=%b st=%0d expected ctl=1010 st=1", ctl, bus.ctrl_state);
        end
        tick();
        ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
        asserts++;
        if (ctl !== 4'b0000 || bus.ctrl_state !== 2'd2 || bus.fwd_sel1 !== 2'd2 || bus.fwd_sel2 !== 2'd0) begin
            failures++;
            $display("FAIL lu_release: ctl=%b st=%0d sel=%0d/%0d expected ctl=0000 st=2 sel=2/0",
                     ctl, bus.ctrl_state, bus.fwd_sel1, bus.fwd_sel2);
        end
        tick();
        drive(1'b1, NOP, 5'd0, 5'd0, 5'd0);
        asserts++;
        if (bus.ctrl_state !== 2'd1 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_back_to_run: st=%0d stall=%b expected st=1 stall=0", bus.ctrl_state, bus.stall);
        end
        drain();
        drive(1'b1, LOAD, 5'd6, 5'd0, 5'd5);
        tick();
        drive(1'b1, STORE, 5'd7, 5'd5, 5'd0);
        asserts++;
        if (bus.stall !== 1'b1 || bus.bubble_id_ex !== 1'b1) begin
            failures++;
            $display("FAIL lu_src2: stall=%b bubble=%b expected 1/1", bus.stall, bus.bubble_id_ex);
        end
        tick();
        asserts++;
        if (bus.fwd_sel2 !== 2'd2 || bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_src2_fwd: sel2=%0d stall=%b expected 2/0", bus.fwd_sel2, bus.stall);
        end
        tick();
        drain();
        drive(1'b1, LOAD, 5'd6, 5'd0, 5'd2);
        tick();
        drive(1'b1, LOADI, 5'd2, 5'd2, 5'd4);
        asserts++;
        if (bus.stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_unused_src: stall=%b expected 0", bus.stall);
        end
        drive(1'b0, ADD, 5'd2, 5'd2, 5'd4);
        asserts++;
        if (bus.stall !== 1'b0 || bus.bubble_id_ex !== 1'b0) begin
            failures++;
            $display("FAIL lu_id_invalid: stall=%b bubble=%b expected 0/0", bus.stall, bus.bubble_id_ex);
        end
        tick();
        drain();
    endtask

    task automatic test_branch();
        logic [3:0] jop [5] = '{JUMPE, JUMPNE, JUMPL, JUMPG, JUMPG};
        logic [2:0] flg [5] = '{3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
        logic       tkn [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0] ctl;
        for (int i = 0; i < 5; i++) begin
            set_flags(1'b0, 1'b0, 1'b0);
            drive(1'b1, CMP, 5'd1, 5'd2, 5'd0);
            tick();
            set_flags(flg[i][2], flg[i][1], flg[i][0]);
            drive(1'b1, jop[i], 5'd3, 5'd0, 5'd0);
            asserts++;
            if (bus.branch_taken !== 1'b0) begin
                failures++;
                $display("FAIL br_cmp_in_ex[%0d]: taken=%b expected 0", i, bus.branch_taken);
            end
            tick();
            set_flags(1'b0, 1'b0, 1'b0);
            drive(1'b1, ADD, 5'd1, 5'd2, 5'd3);
            ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
            asserts++;
            if (bus.flags_q !== flg[i] || ctl !== (tkn[i] ? 4'b0111 : 4'b0000)) begin
                failures++;
                $display("FAIL br_resolve[%0d]: flags=%b ctl=%b expected flags=%b ctl=%b",
                         i, bus.flags_q, ctl, flg[i], tkn[i] ? 4'b0111 : 4'b0000);
            end
            tick();
            drain();
            asserts++;
            if (bus.flags_q !== flg[i] || bus.branch_taken !== 1'b0) begin
                failures++;
                $display("FAIL br_flags_hold[%0d]: flags=%b taken=%b expected %b/0",
                         i, bus.flags_q, bus.branch_taken, flg[i]);
            end
        end
    endtask

    task automatic test_branch_over_load();
        logic [3:0] ctl;
        drive(1'b1, JUMP, 5'd4, 5'd0, 5'd0);
        tick();
        drive(1'b1, LOAD, 5'd6, 5'd0, 5'd2);
        ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
        asserts++;
        if (ctl !== 4'b0111) begin
            failures++;
            $display("FAIL br_over_load: ctl=%b expected 0111", ctl);
        end
        tick();
        drive(1'b1, ADD, 5'd2, 5'd1, 5'd3);
        ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
        asserts++;
        if (ctl !== 4'b0000 || bus.ctrl_state !== 2'd1 || bus.fwd_sel1 !== 2'd0) begin
            failures++;
            $display("FAIL br_squashed_load: ctl=%b st=%0d sel1=%0d expected ctl=0000 st=1 sel1=0",
                     ctl, bus.ctrl_state, bus.fwd_sel1);
        end
        tick();
        drain();
    endtask

    task automatic test_zero_reg();
        drive(1'b1, ADD, 5'd1, 5'd2, 5'd0);
        tick();
        drive(1'b1, SUB, 5'd0, 5'd0, 5'd4);
        asserts++;
        if ({bus.fwd_sel1, bus.fwd_sel2} !== 4'b0000) begin
            failures++;
            $display("FAIL zero_fwd: sel=%0d/%0d expected 0/0", bus.fwd_sel1, bus.fwd_sel2);
        end
        tick();
        drain();
        drive(1'b1, LOAD, 5'd6, 5'd0, 5'd0);
        tick();
        drive(1'b1, ADD, 5'd0, 5'd0, 5'd3);
        asserts++;
        if (bus.stall !== 1'b0 || bus.bubble_id_ex !== 1'b0) begin
            failures++;
            $display("FAIL zero_load_use: stall=%b bubble=%b expected 0/0", bus.stall, bus.bubble_id_ex);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_mid_stall();
        logic [3:0] ctl;
        set_flags(1'b0, 1'b0, 1'b0);
        drive(1'b1, CMP, 5'd1, 5'd2, 5'd0);
        tick();
        set_flags(1'b0, 1'b1, 1'b1);
        drive(1'b1, LOAD, 5'd6, 5'd0, 5'd2);
        tick();
        set_flags(1'b0, 1'b0, 1'b0);
        drive(1'b1, ADD, 5'd2, 5'd1, 5'd3);
        tick();
        asserts++;
        if (bus.ctrl_state !== 2'd2 || bus.flags_q !== 3'b011 || bus.fwd_sel1 !== 2'd2) begin
            failures++;
            $display("FAIL mid_setup: st=%0d flags=%b sel1=%0d expected st=2 flags=011 sel1=2",
                     bus.ctrl_state, bus.flags_q, bus.fwd_sel1);
        end
        reset = 1'b1;
        #1;
        ctl = {bus.stall, bus.flush_if_id, bus.bubble_id_ex, bus.branch_taken};
        asserts++;
        if (ctl !== 4'b1110 || bus.ctrl_state !== 2'd0 || bus.flags_q !== 3'b000 || bus.fwd_sel1 !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset_async: ctl=%b st=%0d flags=%b sel1=%0d expected ctl=1110 st=0 flags=000 sel1=0",
                     ctl, bus.ctrl_state, bus.flags_q, bus.fwd_sel1);
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            asserts++;
            if (bus.ctrl_state !== 2'd0 || bus.stall !== 1'b1 || bus.flush_if_id !== 1'b1) begin
                failures++;
                $display("FAIL mid_reinit[%0d]: st=%0d stall=%b flush=%b expected st=0 stall=1 flush=1",
                         i, bus.ctrl_state, bus.stall, bus.flush_if_id);
            end
            tick();
        end
        asserts++;
        if (bus.ctrl_state !== 2'd1 || bus.stall !== 1'b0 || bus.fwd_sel1 !== 2'd0) begin
            failures++;
            $display("FAIL mid_rerun: st=%0d stall=%b sel1=%0d expected st=1 stall=0 sel1=0",
                     bus.ctrl_state, bus.stall, bus.fwd_sel1);
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_branch_over_load();
        test_zero_reg();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before the end of test");
        $fatal(1);
    end
endmodule
